// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

    localparam int unsigned MAX_LANES = 32;
    localparam int unsigned MAX_IDX_W = $clog2(MAX_LANES);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // One-hot vector with bit idx set; zero if idx is outside the lane range.
    function automatic logic [MAX_LANES-1:0] onehot(input int unsigned idx, input int unsigned lanes);
        logic [MAX_LANES-1:0] v;
        v = '0;
        if (idx < lanes && idx < MAX_LANES) begin
            v[idx[MAX_IDX_W-1:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin search: first set request starting at rr_ptr, wrapping modulo LANES.
module rr_pick #(
    parameter  int unsigned LANES = 4,
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int unsigned pos;

    // Scan farthest-to-nearest so the lane closest to rr_ptr is written last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned k = LANES; k > 0; k--) begin
            pos = (32'(rr_ptr) + k - 1) % LANES;
            if (req[IDX_W'(pos)]) begin
                valid = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Registered round-robin owner of the bus mux lane_select, with a 1-cycle gap between owners.
// Optional hold limit with timeout pre-emption is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int unsigned LANES    = 4,
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned IDX_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] req,
    output logic [LANES-1:0] grant,
    output logic [IDX_W-1:0] grant_id,
    output logic             bus_busy,
    output logic             timeout
);

    arb_state_t       state_q, state_d;
    logic [LANES-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic             bus_busy_q, bus_busy_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;
`else
    // The hold limit is compiled out, so MAX_HOLD has no effect in this build.
    if (MAX_HOLD == 0) begin : g_max_hold_unused
    end
`endif

    rr_pick #(.LANES(LANES)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        bus_busy_d = bus_busy_q;
        rr_ptr_d   = rr_ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    grant_d    = LANES'(onehot(32'(pick_idx), LANES));
                    grant_id_d = pick_idx;
                    bus_busy_d = 1'b1;
                    rr_ptr_d   = (pick_idx == IDX_W'(LANES - 1)) ? '0 : pick_idx + IDX_W'(1);
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_cnt_d = HOLD_W'(1);
`endif
                end
            end
            GRANT: begin
                if (!req[grant_id_q]) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    bus_busy_d = 1'b0;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    bus_busy_d = 1'b0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            bus_busy_q <= 1'b0;
            rr_ptr_q   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            bus_busy_q <= bus_busy_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign bus_busy = bus_busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized requests vs. a reference model.
module tb_bus_arbiter;

    localparam int unsigned L        = 4;
    localparam int unsigned MAX_HOLD = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [L-1:0] req;
    logic [L-1:0] grant;
    logic [1:0]   grant_id;
    logic         bus_busy;
    logic         timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    bus_arbiter #(.LANES(L), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: current owner (-1 = idle), priority pointer, consecutive hold count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < L; k++) begin
                    int p;
                    p = (m_ptr + k) % L;
                    if (req[p] && m_owner < 0) begin
                        m_owner = p;
                        m_ptr   = (p + 1) % L;
                        m_hold  = 1;
                    end
                end
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end else if (TO_EN && m_hold == MAX_HOLD) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_hold++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, plus structural invariants.
    always @(negedge clk) begin
        int idx;
        idx = 0;
        for (int i = 0; i < L; i++) if (grant[i]) idx = i;
        check("grant",    32'(grant),    (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("grant_id", 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("bus_busy", 32'(bus_busy), (m_owner < 0) ? 32'd0 : 32'd1);
        check("timeout",  32'(timeout),  32'(m_to));
        check("onehot0",  32'($onehot0(grant)), 32'd1);
        check("busy_or",  32'(bus_busy), 32'(|grant));
        if (bus_busy) check("id_match", 32'(grant_id), 32'(idx));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [L-1:0] rr_req [13] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1101, 4'b1111,
                                  4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b0111, 4'b1111};
    logic [L-1:0] rr_exp [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                                  4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    logic [L-1:0] wr_req [7]  = '{4'b0000, 4'b0100, 4'b0000, 4'b1001, 4'b0001, 4'b0001, 4'b0000};
    logic [L-1:0] wr_exp [7]  = '{4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    initial begin
        // Reset while every lane requests.
        rst_n = 1'b0;
        req   = 4'b1111;
        step();
        step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_id",    32'(grant_id), 32'd0);
        check("rst_busy",  32'(bus_busy), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_rel_grant", 32'(grant), 32'b0001);
        req = 4'b0000;
        step();
        check("rst_rel_drop", 32'(grant), 32'd0);

        // Single requester held for five cycles.
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            check("single_hold", 32'(grant), 32'b0100);
            check("single_id",   32'(grant_id), 32'd2);
        end
        req = 4'b0000;
        step();
        check("single_drop", 32'(grant), 32'd0);

        // Round-robin rotation from a fresh pointer.
        pulse_reset();
        for (int i = 0; i < 13; i++) begin
            req = rr_req[i];
            step();
            check("rr_order", 32'(grant), 32'(rr_exp[i]));
        end

        // Pointer wrap from lane 3 back to lane 0.
        for (int i = 0; i < 7; i++) begin
            req = wr_req[i];
            step();
            check("wrap", 32'(grant), 32'(wr_exp[i]));
        end

        // Asynchronous reset between edges drops the grant immediately.
        req = 4'b0010;
        step();
        check("async_pre", 32'(grant), 32'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_busy",  32'(bus_busy), 32'd0);
        req = 4'b0000;
        step();
        rst_n = 1'b1;
        step();

        // Two lanes held: hold limit with timeout when enabled, indefinite hold otherwise.
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            step();
            if (TO_EN) begin
                check("hold_grant", 32'(grant), (i < 8) ? 32'b0001 : ((i == 8) ? 32'd0 : 32'b0010));
                check("hold_to",    32'(timeout), (i == 8) ? 32'd1 : 32'd0);
            end else begin
                check("hold_grant", 32'(grant), 32'b0001);
                check("hold_to",    32'(timeout), 32'd0);
            end
        end
        req = 4'b0000;
        step();

        // Randomized requests with persistence and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end
            if ($urandom_range(0, 3) == 0) req = L'($urandom_range(0, 15));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
